// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: shift opcodes and shift-unit FSM encoding.
package mips_pkg;

   localparam logic [1:0] SH_SLL = 2'b00;
   localparam logic [1:0] SH_SRL = 2'b01;
   localparam logic [1:0] SH_SRA = 2'b10;
   localparam logic [1:0] SH_RSV = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_SHIFT = 2'b01,
      ST_DONE  = 2'b10
   } sh_state_t;

   function automatic logic is_rsv(input logic [1:0] op);
      return (op == SH_RSV);
   endfunction

endpackage

// File: rtl/iterative_shift_unit_if.sv
// Request/response bundle between the ALU controller (master) and the shift unit (slave).
interface iterative_shift_unit_if #(
   parameter int N = 32
);
   localparam int SW = $clog2(N);

   logic          start;
   logic [1:0]    op;
   logic [N-1:0]  a;
   logic [SW-1:0] shamt;
   logic          ready;
   logic          busy;
   logic          done;
   logic          err;
   logic [N-1:0]  z;

   modport master (
      output start, op, a, shamt,
      input  ready, busy, done, err, z
   );

   modport slave (
      input  start, op, a, shamt,
      output ready, busy, done, err, z
   );
endinterface

// File: rtl/iterative_shift_unit_shift_step.sv
// One combinational shift slice: moves acc by k (k <= STEP) in the direction given by op.
module shift_step
   import mips_pkg::*;
#(
   parameter int n  = 32,
   parameter int SW = $clog2(n)
) (
   input  logic [n-1:0]  i_acc,
   input  logic [1:0]    i_op,
   input  logic [SW-1:0] i_k,
   output logic [n-1:0]  o_acc
);

   logic signed [n-1:0] w_sacc;
   logic signed [n-1:0] w_sra;

   assign w_sacc = i_acc;
   assign w_sra  = w_sacc >>> i_k;

   // Direction select; reserved op passes the operand through untouched.
   always_comb begin
      o_acc = i_acc;
      case (i_op)
         SH_SLL:  o_acc = i_acc << i_k;
         SH_SRL:  o_acc = i_acc >> i_k;
         SH_SRA:  o_acc = w_sra;
         default: o_acc = i_acc;
      endcase
   end

endmodule

// File: rtl/iterative_shift_unit.sv
// Multi-cycle SLL/SRL/SRA unit: shifts a captured operand by up to STEP bits per clock.
module iterative_shift_unit
   import mips_pkg::*;
#(
   parameter int n    = 32,
   parameter int STEP = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   iterative_shift_unit_if.slave bus
);

   localparam int            SW     = $clog2(n);
   localparam logic [SW-1:0] STEP_K = SW'(STEP);

   sh_state_t     r_state;
   logic [n-1:0]  r_acc;
   logic [SW-1:0] r_rem;
   logic [1:0]    r_op;
   logic [n-1:0]  r_z;
   logic          r_done;
   logic          r_err;
   logic          r_ready;
   logic          r_busy;

   sh_state_t     w_state_nxt;
   logic [n-1:0]  w_acc_nxt;
   logic [SW-1:0] w_rem_nxt;
   logic [1:0]    w_op_nxt;
   logic [n-1:0]  w_z_nxt;
   logic          w_done_nxt;
   logic          w_err_nxt;
   logic [SW-1:0] w_k;
   logic [n-1:0]  w_shifted;

   // The final step may be shorter than STEP when the remaining amount is small.
   assign w_k = (r_rem < STEP_K) ? r_rem : STEP_K;

   shift_step #(
      .n  (n),
      .SW (SW)
   ) u_step (
      .i_acc (r_acc),
      .i_op  (r_op),
      .i_k   (w_k),
      .o_acc (w_shifted)
   );

   // Next-state and datapath update; done/err are decided here so they align with ST_DONE.
   always_comb begin
      w_state_nxt = r_state;
      w_acc_nxt   = r_acc;
      w_rem_nxt   = r_rem;
      w_op_nxt    = r_op;
      w_z_nxt     = r_z;
      w_done_nxt  = 1'b0;
      w_err_nxt   = 1'b0;
      case (r_state)
         ST_IDLE, ST_DONE: begin
            if (bus.start) begin
               w_acc_nxt = bus.a;
               w_op_nxt  = bus.op;
               w_rem_nxt = bus.shamt;
               if ((bus.shamt == {SW{1'b0}}) || is_rsv(bus.op)) begin
                  w_state_nxt = ST_DONE;
                  w_z_nxt     = bus.a;
                  w_done_nxt  = 1'b1;
                  w_err_nxt   = is_rsv(bus.op);
               end else begin
                  w_state_nxt = ST_SHIFT;
               end
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_SHIFT: begin
            w_acc_nxt = w_shifted;
            w_rem_nxt = r_rem - w_k;
            if (r_rem == w_k) begin
               w_state_nxt = ST_DONE;
               w_z_nxt     = w_shifted;
               w_done_nxt  = 1'b1;
               w_err_nxt   = is_rsv(r_op);
            end else begin
               w_state_nxt = ST_SHIFT;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers; ready/busy are registered from the next state.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_acc   <= {n{1'b0}};
         r_rem   <= {SW{1'b0}};
         r_op    <= SH_SLL;
         r_z     <= {n{1'b0}};
         r_done  <= 1'b0;
         r_err   <= 1'b0;
         r_ready <= 1'b1;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_acc   <= w_acc_nxt;
         r_rem   <= w_rem_nxt;
         r_op    <= w_op_nxt;
         r_z     <= w_z_nxt;
         r_done  <= w_done_nxt;
         r_err   <= w_err_nxt;
         r_ready <= (w_state_nxt != ST_SHIFT);
         r_busy  <= (w_state_nxt == ST_SHIFT);
      end
   end

   assign bus.ready = r_ready;
   assign bus.busy  = r_busy;
   assign bus.done  = r_done;
   assign bus.err   = r_err;
   assign bus.z     = r_z;

endmodule

// File: tb/tb_iterative_shift_unit.sv
// Self-checking bench: STEP=1 and STEP=4 instances, vector table plus scoreboard of expected results.
module tb_iterative_shift_unit;

   localparam int N  = 32;
   localparam int SW = 5;

   logic          clk = 1'b0;
   logic          rst;
   logic          sel;
   logic          tb_start;
   logic [1:0]    tb_op;
   logic [N-1:0]  tb_a;
   logic [SW-1:0] tb_shamt;

   always #5 clk = ~clk;

   iterative_shift_unit_if #(.N(N)) bus1 ();
   iterative_shift_unit_if #(.N(N)) bus4 ();

   assign bus1.start = tb_start & ~sel;
   assign bus4.start = tb_start & sel;
   assign bus1.op    = tb_op;
   assign bus4.op    = tb_op;
   assign bus1.a     = tb_a;
   assign bus4.a     = tb_a;
   assign bus1.shamt = tb_shamt;
   assign bus4.shamt = tb_shamt;

   iterative_shift_unit #(.n(N), .STEP(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
   iterative_shift_unit #(.n(N), .STEP(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

   logic         o_done, o_err, o_ready, o_busy;
   logic [N-1:0] o_z;
   assign o_done  = sel ? bus4.done  : bus1.done;
   assign o_err   = sel ? bus4.err   : bus1.err;
   assign o_ready = sel ? bus4.ready : bus1.ready;
   assign o_busy  = sel ? bus4.busy  : bus1.busy;
   assign o_z     = sel ? bus4.z     : bus1.z;

   typedef struct {
      bit           s;
      logic [1:0]   op;
      logic [N-1:0] a;
      logic [SW-1:0] shamt;
      logic [N-1:0] exp_z;
      bit           exp_err;
   } vec_t;

   typedef struct {
      logic [N-1:0] z;
      bit           err;
      int           lat;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [N-1:0] ref_shift(input logic [1:0] op, input logic [N-1:0] a,
                                              input logic [SW-1:0] sh);
      logic signed [N-1:0] sa;
      sa = a;
      case (op)
         2'b00:   return a << sh;
         2'b01:   return a >> sh;
         2'b10:   return sa >>> sh;
         default: return a;
      endcase
   endfunction

   // Issue one op; b2b_in: already at the done negedge; b2b_out: leave without the pulse check.
   task automatic run_op(input bit s, input logic [1:0] op, input logic [N-1:0] a,
                         input logic [SW-1:0] sh, input logic [N-1:0] exp_z, input bit exp_err,
                         input bit b2b_in, input bit b2b_out);
      exp_t e;
      int   lat;
      int   step;
      step  = s ? 4 : 1;
      e.z   = exp_z;
      e.err = exp_err;
      e.lat = (op == 2'b11) ? 0 : (int'(sh) + step - 1) / step;
      if (!b2b_in) @(negedge clk);
      sel = s; tb_start = 1'b1; tb_op = op; tb_a = a; tb_shamt = sh;
      sb.push_back(e);
      @(posedge clk);
      @(negedge clk);
      tb_start = 1'b0;
      tb_a     = ~a;
      if (e.lat > 0) begin
         chk("busy_in_shift", {31'b0, o_busy}, 32'd1);
         chk("ready_in_shift", {31'b0, o_ready}, 32'd0);
      end
      lat = 0;
      while (!o_done && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      e = sb.pop_front();
      chk("done_seen", {31'b0, o_done}, 32'd1);
      chk("latency", lat, e.lat);
      chk("z", o_z, e.z);
      chk("err", {31'b0, o_err}, {31'b0, e.err});
      chk("ready_at_done", {31'b0, o_ready}, 32'd1);
      if (!b2b_out) begin
         @(negedge clk);
         chk("done_one_cycle", {31'b0, o_done}, 32'd0);
         chk("z_hold", o_z, e.z);
      end
   endtask

   vec_t vecs[12];
   exp_t e_busy;
   int   lat_b;

   initial begin
      vecs[0]  = '{1'b0, 2'b00, 32'h0000_0001, 5'd31, 32'h8000_0000, 1'b0};
      vecs[1]  = '{1'b0, 2'b10, 32'hF000_0000, 5'd4,  32'hFF00_0000, 1'b0};
      vecs[2]  = '{1'b0, 2'b01, 32'hF000_0000, 5'd4,  32'h0F00_0000, 1'b0};
      vecs[3]  = '{1'b0, 2'b01, 32'h1234_5678, 5'd0,  32'h1234_5678, 1'b0};
      vecs[4]  = '{1'b0, 2'b11, 32'hDEAD_BEEF, 5'd7,  32'hDEAD_BEEF, 1'b1};
      vecs[5]  = '{1'b0, 2'b10, 32'h8000_0001, 5'd31, 32'hFFFF_FFFF, 1'b0};
      vecs[6]  = '{1'b0, 2'b00, 32'hA5A5_A5A5, 5'd8,  32'hA5A5_A500, 1'b0};
      vecs[7]  = '{1'b0, 2'b10, 32'h7FFF_FFFF, 5'd30, 32'h0000_0001, 1'b0};
      vecs[8]  = '{1'b1, 2'b00, 32'h0000_0001, 5'd9,  32'h0000_0200, 1'b0};
      vecs[9]  = '{1'b1, 2'b10, 32'h8000_0000, 5'd9,  32'hFFC0_0000, 1'b0};
      vecs[10] = '{1'b1, 2'b01, 32'hFFFF_FFFF, 5'd31, 32'h0000_0001, 1'b0};
      vecs[11] = '{1'b1, 2'b11, 32'h0BAD_F00D, 5'd3,  32'h0BAD_F00D, 1'b1};

      rst = 1'b1; sel = 1'b0; tb_start = 1'b0; tb_op = 2'b00; tb_a = '0; tb_shamt = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_z", bus1.z, 32'h0);
      chk("rst_done", {31'b0, bus1.done}, 32'd0);
      chk("rst_ready", {31'b0, bus1.ready}, 32'd1);
      chk("rst_busy", {31'b0, bus1.busy}, 32'd0);
      chk("rst_err", {31'b0, bus1.err}, 32'd0);
      chk("rst_z4", bus4.z, 32'h0);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      chk("idle_ready", {31'b0, bus1.ready}, 32'd1);
      chk("idle_done", {31'b0, bus1.done}, 32'd0);

      for (int i = 0; i < 12; i++)
         run_op(vecs[i].s, vecs[i].op, vecs[i].a, vecs[i].shamt, vecs[i].exp_z,
                vecs[i].exp_err, 1'b0, 1'b0);

      for (int i = 0; i < 8; i++) begin
         logic [1:0]    r_op;
         logic [N-1:0]  r_a;
         logic [SW-1:0] r_sh;
         bit            r_s;
         r_op = 2'($urandom_range(0, 2));
         r_a  = $urandom;
         r_sh = 5'($urandom_range(0, 31));
         r_s  = 1'($urandom_range(0, 1));
         run_op(r_s, r_op, r_a, r_sh, ref_shift(r_op, r_a, r_sh), 1'b0, 1'b0, 1'b0);
      end

      // start while busy must not disturb the in-flight SLL
      @(negedge clk);
      sel = 1'b0; tb_start = 1'b1; tb_op = 2'b00; tb_a = 32'h0000_0003; tb_shamt = 5'd5;
      sb.push_back('{32'h0000_0060, 1'b0, 5});
      @(posedge clk);
      @(negedge clk);
      tb_start = 1'b1; tb_op = 2'b11; tb_a = 32'h0; tb_shamt = 5'd0;
      lat_b = 0;
      @(negedge clk);
      lat_b++;
      tb_start = 1'b0; tb_a = 32'hFFFF_FFFF; tb_op = 2'b10;
      while (!o_done && lat_b < 100) begin
         @(negedge clk);
         lat_b++;
      end
      e_busy = sb.pop_front();
      chk("busy_ign_latency", lat_b, e_busy.lat);
      chk("busy_ign_z", o_z, e_busy.z);
      chk("busy_ign_err", {31'b0, o_err}, 32'd0);

      // synchronous reset in the middle of a shift
      @(negedge clk);
      sel = 1'b0; tb_start = 1'b1; tb_op = 2'b00; tb_a = 32'h0000_0001; tb_shamt = 5'd20;
      @(posedge clk);
      @(negedge clk);
      tb_start = 1'b0;
      repeat (3) @(negedge clk);
      chk("pre_rst_busy", {31'b0, o_busy}, 32'd1);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("abort_z", o_z, 32'h0);
      chk("abort_ready", {31'b0, o_ready}, 32'd1);
      chk("abort_busy", {31'b0, o_busy}, 32'd0);
      chk("abort_done", {31'b0, o_done}, 32'd0);
      rst = 1'b0;
      run_op(1'b0, 2'b01, 32'h8000_0000, 5'd3, 32'h1000_0000, 1'b0, 1'b0, 1'b0);

      // back-to-back accept from DONE
      run_op(1'b0, 2'b00, 32'h0000_0001, 5'd2, 32'h0000_0004, 1'b0, 1'b0, 1'b1);
      run_op(1'b0, 2'b01, 32'h0000_0080, 5'd3, 32'h0000_0010, 1'b0, 1'b1, 1'b1);
      run_op(1'b0, 2'b11, 32'hCAFE_0001, 5'd1, 32'hCAFE_0001, 1'b1, 1'b1, 1'b0);
      run_op(1'b1, 2'b00, 32'h0000_0001, 5'd4, 32'h0000_0010, 1'b0, 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
